// File: rtl/avalon_bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_bram_pkg
//  Description : Shared types and helpers for the Avalon-MM burst BRAM slave.
//                Provides the controller state encoding, the burst-length
//                normalisation rule and the burst address stepping rule.
//  Revision    : 1.0  initial release
// ============================================================================
package avalon_bram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // Largest burst a BURSTCOUNT_W-bit burstcount may request.
    function automatic int unsigned calc_maxb(input int unsigned bw);
        return 32'd1 << (bw - 32'd1);
    endfunction

    // A burstcount of zero still moves one beat; oversize requests saturate.
    function automatic logic [31:0] burst_len(input logic [31:0] bc,
                                              input logic [31:0] maxb);
        if (bc == 32'd0) begin
            return 32'd1;
        end
        if (bc > maxb) begin
            return maxb;
        end
        return bc;
    endfunction

    // Word address following addr inside a burst of len beats. Wrapping only
    // applies to power-of-two lengths; otherwise the step is linear. The
    // caller truncates the result to the RAM word width (modulo depth).
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [31:0] len,
                                              input logic        wrap);
        logic [31:0] mask;
        logic [31:0] inc;
        inc  = addr + 32'd1;
        mask = len - 32'd1;
        if (wrap && ((len & mask) == 32'd0)) begin
            return (addr & ~mask) | (inc & mask);
        end
        return inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_bram_burst_bram.sv
`default_nettype none
// ============================================================================
//  Module      : bram_be
//  Description : Single-port synchronous RAM with per-byte write enables.
//                One-cycle read latency; a lane written in the same cycle it
//                is read returns the new byte (write-first per lane).
//  Ports       : clk      - clock
//                rst_n    - async active-low reset (read register only)
//                we_i     - write enable
//                addr_i   - word address
//                be_i     - byte-lane enables for writes
//                wdata_i  - write data
//                rdata_o  - registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module bram_be #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_BYTES-1:0]   be_i,
    input  logic [8*DATA_BYTES-1:0] wdata_i,
    output logic [8*DATA_BYTES-1:0] rdata_o
);

    logic [8*DATA_BYTES-1:0] mem_q [2**ADDR_W];
    logic [8*DATA_BYTES-1:0] rdata_q;

    // Storage array carries no reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (we_i && be_i[b]) begin
                    rdata_q[8*b +: 8] <= wdata_i[8*b +: 8];
                end else begin
                    rdata_q[8*b +: 8] <= mem_q[addr_i][8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/avalon_bram_burst.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_bram_burst
//  Description : Avalon-MM burst slave in front of a byte-enabled single-port
//                BRAM. Supports linear or wrapping bursts, an optional output
//                register and back-to-back pipelined read bursts.
//  Ports       : clk           - clock, rising edge
//                reset         - async active-low reset
//                address       - byte address (first beat only)
//                byteenable    - per-byte write enable (every write beat)
//                read / write  - command strobes
//                writedata     - write data
//                burstcount    - beats in burst (first beat only)
//                readdata      - read data
//                readdatavalid - one pulse per returned read beat
//                waitrequest   - slave stall
//  Revision    : 1.0  initial release
// ============================================================================
module avalon_bram_burst
    import avalon_bram_pkg::*;
#(
    parameter int DATA_BYTES   = 4,
    parameter int ADDR_W       = 32,
    parameter int BURSTCOUNT_W = 6,
    parameter int RAM_ADD_W    = 11,
    parameter int OUT_REG      = 0,
    parameter int WRAP_BURST   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_BYTES-1:0]   byteenable,
    input  logic                    read,
    input  logic                    write,
    input  logic [8*DATA_BYTES-1:0] writedata,
    input  logic [BURSTCOUNT_W-1:0] burstcount,
    output logic [8*DATA_BYTES-1:0] readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest
);

    localparam int          DATA_W  = 8 * DATA_BYTES;
    localparam int          BYTE_W  = $clog2(DATA_BYTES);
    localparam int unsigned MAXB    = calc_maxb(BURSTCOUNT_W);
    localparam int          VLD_W   = 1 + OUT_REG;
    localparam logic        WRAP_EN = (WRAP_BURST != 0);
    localparam logic [BURSTCOUNT_W-1:0] LEN_ONE = 1;

    state_t                  state_q;
    logic [RAM_ADD_W-1:0]    addr_q;
    logic [BURSTCOUNT_W-1:0] rem_q;
    logic [BURSTCOUNT_W-1:0] len_q;
    logic                    wait_q;
    logic [VLD_W-1:0]        vld_q;

    logic [RAM_ADD_W-1:0]    w_word;
    logic [BURSTCOUNT_W-1:0] w_len;
    logic [RAM_ADD_W-1:0]    w_cmd_next;
    logic [RAM_ADD_W-1:0]    w_burst_next;
    logic [RAM_ADD_W-1:0]    w_ram_addr;
    logic                    w_ram_we;
    logic                    w_issue;
    logic [DATA_W-1:0]       w_ram_rdata;
    logic                    w_unused;

    // Bits above the RAM window alias; bits below the word are ignored.
    assign w_word   = address[RAM_ADD_W+BYTE_W-1 : BYTE_W];
    assign w_unused = ^address;

    assign w_len        = BURSTCOUNT_W'(burst_len(32'(burstcount), 32'(MAXB)));
    assign w_cmd_next   = RAM_ADD_W'(next_addr(32'(w_word), 32'(w_len), WRAP_EN));
    assign w_burst_next = RAM_ADD_W'(next_addr(32'(addr_q), 32'(len_q), WRAP_EN));

    // The first beat of any command uses the live address; later beats use
    // the stepped address held in addr_q.
    always_comb begin
        w_ram_addr = addr_q;
        w_ram_we   = 1'b0;
        w_issue    = 1'b0;
        unique case (state_q)
            IDLE: begin
                w_ram_addr = w_word;
                if (!wait_q) begin
                    if (write) begin
                        w_ram_we = 1'b1;
                    end else if (read) begin
                        w_issue = 1'b1;
                    end
                end
            end
            WRITE: begin
                w_ram_we = write;
            end
            READ: begin
                w_issue = 1'b1;
            end
            default: begin
                w_ram_addr = addr_q;
            end
        endcase
    end

    // wait_q resets high, so the first cycle after reset release still stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            wait_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    wait_q <= 1'b0;
                    if (!wait_q && (write || read) && (w_len > LEN_ONE)) begin
                        rem_q  <= w_len - LEN_ONE;
                        len_q  <= w_len;
                        addr_q <= w_cmd_next;
                        if (write) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                            wait_q  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wait_q <= 1'b0;
                    if (write) begin
                        addr_q <= w_burst_next;
                        rem_q  <= rem_q - LEN_ONE;
                        if (rem_q == LEN_ONE) begin
                            state_q <= IDLE;
                        end
                    end
                end
                READ: begin
                    addr_q <= w_burst_next;
                    rem_q  <= rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_q <= IDLE;
                        wait_q  <= 1'b0;
                    end else begin
                        wait_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wait_q  <= 1'b1;
                end
            endcase
        end
    end

    // Issue strobes ride a shift register matching the data path latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= VLD_W'({vld_q, w_issue});
        end
    end

    bram_be #(
        .DATA_BYTES (DATA_BYTES),
        .ADDR_W     (RAM_ADD_W)
    ) u_bram (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (w_ram_we),
        .addr_i  (w_ram_addr),
        .be_i    (byteenable),
        .wdata_i (writedata),
        .rdata_o (w_ram_rdata)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rdata_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= w_ram_rdata;
                end
            end
            assign readdata = rdata_q;
        end else begin : g_no_out_reg
            assign readdata = w_ram_rdata;
        end
    endgenerate

    assign readdatavalid = vld_q[VLD_W-1];
    assign waitrequest   = wait_q;

    // Simultaneous read and write is a master protocol violation.
    a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset) !(read && write));

endmodule
`default_nettype wire

// File: tb/tb_avalon_bram_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_bram_burst
//  Description : Self-checking bench for avalon_bram_burst. Two instances
//                (linear/no output register, wrapping/output register) share
//                one stimulus stream and are compared every cycle against a
//                behavioural memory-and-timing model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_avalon_bram_burst;

    localparam int DB    = 4;
    localparam int AW    = 32;
    localparam int BW    = 6;
    localparam int RW    = 11;
    localparam int DEPTH = 2048;
    localparam int MAXB  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DB-1:0] byteenable = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [BW-1:0] burstcount = '0;
    logic [31:0]   readdata0, readdata1;
    logic          rdv0, rdv1, wr0, wr1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_bram_burst #(.DATA_BYTES(DB), .ADDR_W(AW), .BURSTCOUNT_W(BW),
                        .RAM_ADD_W(RW), .OUT_REG(0), .WRAP_BURST(0)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .read(read), .write(write), .writedata(writedata), .burstcount(burstcount),
        .readdata(readdata0), .readdatavalid(rdv0), .waitrequest(wr0));

    avalon_bram_burst #(.DATA_BYTES(DB), .ADDR_W(AW), .BURSTCOUNT_W(BW),
                        .RAM_ADD_W(RW), .OUT_REG(1), .WRAP_BURST(1)) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .read(read), .write(write), .writedata(writedata), .burstcount(burstcount),
        .readdata(readdata1), .readdatavalid(rdv1), .waitrequest(wr1));

    // ---------------- behavioural model ----------------
    typedef struct { int cyc; logic [31:0] data; } exp_t;
    logic [31:0] mem0 [DEPTH];
    logic [31:0] mem1 [DEPTH];
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] log0[$];
    logic [31:0] log1[$];
    int          ready_cyc = 1 << 30;
    int          rd_from = -1;
    int          rd_to = -1;
    int          run0 = 0, run1 = 0, maxrun0 = 0, maxrun1 = 0;
    logic [31:0] wd  [64];
    logic [3:0]  wbe [64];
    int          checks = 0;
    int          failures = 0;
    logic        ew, ev0, ev1;

    function automatic int mlen(input int bc);
        if (bc == 0) return 1;
        if (bc > MAXB) return MAXB;
        return bc;
    endfunction

    // Word touched by beat k of a burst starting at w0.
    function automatic int beat_word(input int w0, input int len, input int wrap, input int k);
        int base;
        if (wrap != 0 && (len & (len - 1)) == 0) begin
            base = w0 - (w0 % len);
            return base + ((w0 % len + k) % len);
        end
        return (w0 + k) % DEPTH;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(input int w);
        logic [31:0] a;
        a = $urandom;
        a[12:2] = 11'(w);
        return a;
    endfunction

    function automatic bit is_free();
        return (reset == 1'b1) && (cyc >= ready_cyc) && (cyc > rd_to);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_wait0", 64'(wr0), 64'd1);
            chk("rst_wait1", 64'(wr1), 64'd1);
            chk("rst_valid0", 64'(rdv0), 64'd0);
            chk("rst_valid1", 64'(rdv1), 64'd0);
            chk("rst_data0", 64'(readdata0), 64'd0);
            chk("rst_data1", 64'(readdata1), 64'd0);
        end else begin
            ew  = (cyc < ready_cyc) || (cyc > rd_from && cyc <= rd_to);
            chk("wait0", 64'(wr0), 64'(ew));
            chk("wait1", 64'(wr1), 64'(ew));
            ev0 = (q0.size() > 0) && (q0[0].cyc == cyc);
            ev1 = (q1.size() > 0) && (q1[0].cyc == cyc);
            chk("valid0", 64'(rdv0), 64'(ev0));
            chk("valid1", 64'(rdv1), 64'(ev1));
            if (ev0) begin
                chk("data0", 64'(readdata0), 64'(q0[0].data));
                void'(q0.pop_front());
            end
            if (ev1) begin
                chk("data1", 64'(readdata1), 64'(q1[0].data));
                void'(q1.pop_front());
            end
        end
        if (rdv0 === 1'b1) begin
            log0.push_back(readdata0);
            run0++;
            if (run0 > maxrun0) maxrun0 = run0;
        end else run0 = 0;
        if (rdv1 === 1'b1) begin
            log1.push_back(readdata1);
            run1++;
            if (run1 > maxrun1) maxrun1 = run1;
        end else run1 = 0;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic wait_free();
        int n;
        n = 0;
        while (!is_free() && n < 200) begin
            idle_in();
            step();
            n++;
        end
        if (!is_free()) chk("wait_free_timeout", 64'(n), 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 300) begin
            idle_in();
            step();
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0) chk("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
        step();
    endtask

    task automatic write_burst(input int w, input int bc, input int gap_at, input int gap_len);
        int len;
        len = mlen(bc);
        wait_free();
        for (int k = 0; k < len; k++) begin
            if (k == gap_at && k > 0) begin
                for (int g = 0; g < gap_len; g++) begin
                    write = 1'b0;
                    read  = 1'b1;            // must be ignored mid-burst
                    address = $urandom;
                    burstcount = BW'($urandom);
                    step();
                end
            end
            read  = 1'b0;
            write = 1'b1;
            writedata  = wd[k];
            byteenable = wbe[k];
            if (k == 0) begin
                address    = mk_addr(w);
                burstcount = BW'(bc);
            end else begin
                address    = $urandom;
                burstcount = BW'($urandom);
            end
            mem0[beat_word(w, len, 0, k)] = merge(mem0[beat_word(w, len, 0, k)], wd[k], wbe[k]);
            mem1[beat_word(w, len, 1, k)] = merge(mem1[beat_word(w, len, 1, k)], wd[k], wbe[k]);
            step();
        end
        write = 1'b0;
    endtask

    task automatic read_burst(input int w, input int bc);
        int len;
        len = mlen(bc);
        wait_free();
        read = 1'b1;
        address = mk_addr(w);
        burstcount = BW'(bc);
        for (int k = 0; k < len; k++) begin
            q0.push_back('{cyc + 1 + k, mem0[beat_word(w, len, 0, k)]});
            q1.push_back('{cyc + 2 + k, mem1[beat_word(w, len, 1, k)]});
        end
        rd_from = cyc;
        rd_to   = cyc + len - 1;
        step();
        read = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        rd_from = -1;
        rd_to   = -1;
        idle_in();
        repeat (hold) step();
        reset = 1'b1;
        ready_cyc = cyc + 1;
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 reset = 1'b0;
        read = 1'b1;
        address = 32'h40;
        burstcount = 6'd4;
        repeat (3) step();
        reset = 1'b1;
        read  = 1'b0;
        ready_cyc = cyc + 1;
        step();
        @(negedge clk);
        chk("wait_release", 64'(wr0), 64'd0);

        // Prefill words 0..127 with aligned 32-beat bursts.
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 64; k++) begin wd[k] = $urandom; wbe[k] = 4'hF; end
            write_burst(32 * b, 32, -1, 0);
        end

        // Linear 8-beat write/read at byte 0x40 (word 16).
        for (int k = 0; k < 8; k++) begin wd[k] = 32'h1000 + k; wbe[k] = 4'hF; end
        write_burst(16, 8, -1, 0);
        drain();
        clear_logs();
        read_burst(16, 8);
        drain();
        chk("lin_count", 64'(log0.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < log0.size()) chk("lin_lit0", 64'(log0[k]), 64'(32'h1000 + k));
            if (k < log1.size()) chk("lin_lit1", 64'(log1[k]), 64'(32'h1000 + k));
        end

        // Byte-enable merge.
        wd[0] = 32'hAABBCCDD; wbe[0] = 4'hF;
        write_burst(40, 1, -1, 0);
        wd[0] = 32'h11223344; wbe[0] = 4'h5;
        write_burst(40, 1, -1, 0);
        clear_logs();
        read_burst(40, 1);
        drain();
        chk("be_model", 64'(mem0[40]), 64'hAA22CC44);
        chk("be_count", 64'(log0.size()), 64'd1);
        if (log0.size() > 0) chk("be_lit", 64'(log0[0]), 64'hAA22CC44);

        // Write gaps and burstcount 0.
        for (int k = 0; k < 4; k++) begin wd[k] = 32'h5000 + k; wbe[k] = 4'hF; end
        write_burst(48, 4, 2, 2);
        clear_logs();
        read_burst(48, 4);
        drain();
        for (int k = 0; k < 4; k++)
            if (k < log0.size()) chk("gap_lit", 64'(log0[k]), 64'(32'h5000 + k));
        clear_logs();
        read_burst(49, 0);
        drain();
        chk("bc0_count0", 64'(log0.size()), 64'd1);
        chk("bc0_count1", 64'(log1.size()), 64'd1);
        if (log0.size() > 0) chk("bc0_lit", 64'(log0[0]), 64'h5001);

        // Wrap order and back-to-back bursts.
        for (int k = 0; k < 4; k++) begin wd[k] = 32'h7000 + k; wbe[k] = 4'hF; end
        write_burst(4, 4, -1, 0);
        drain();
        clear_logs();
        maxrun0 = 0;
        maxrun1 = 0;
        read_burst(6, 4);
        read_burst(0, 4);
        drain();
        chk("b2b_run0", 64'(maxrun0), 64'd8);
        chk("b2b_run1", 64'(maxrun1), 64'd8);
        chk("wrap_count", 64'(log1.size()), 64'd8);
        if (log1.size() >= 4) begin
            chk("wrap_lit0", 64'(log1[0]), 64'h7002);
            chk("wrap_lit1", 64'(log1[1]), 64'h7003);
            chk("wrap_lit2", 64'(log1[2]), 64'h7000);
            chk("wrap_lit3", 64'(log1[3]), 64'h7001);
        end
        if (log0.size() >= 2) chk("lin_nowrap", 64'(log0[2 - 2 + 1]), 64'h7003);

        // Reset during beat 3 of a 16-beat read.
        clear_logs();
        read_burst(0, 16);
        repeat (3) step();
        do_reset(2);
        chk("midrst_beats0", 64'(log0.size()), 64'd3);
        chk("midrst_beats1", 64'(log1.size()), 64'd2);
        clear_logs();
        read_burst(16, 2);
        drain();
        chk("post_rst_count", 64'(log0.size()), 64'd2);
        if (log0.size() > 1) chk("post_rst_lit", 64'(log0[1]), 64'h1001);

        // Randomized mix of bursts.
        for (int i = 0; i < 60; i++) begin
            int w, bc;
            w  = $urandom_range(0, 95);
            bc = $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 64; k++) begin wd[k] = $urandom; wbe[k] = 4'($urandom); end
                write_burst(w, bc, $urandom_range(0, 4), $urandom_range(0, 3));
            end else begin
                read_burst(w, bc);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin idle_in(); step(); end
            end
        end
        drain();
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
